// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable clock dividers.
// Each channel produces a near-50% divided clock and a one-cycle tick.
// Divisors are reloaded through a valid/ready port. A new divisor for a
// running channel is held in a shadow register and only takes effect at
// the next period boundary, so no short periods are ever produced.
module clkdiv_multi #(
   parameter int NCH         = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [CH_W-1:0]  cfg_ch_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   output logic             cfg_err_o,
   output logic [NCH-1:0]   clk_out_o,
   output logic [NCH-1:0]   tick_o,
   output logic [NCH-1:0]   pending_o
);

   logic [CNT_W-1:0] div_q    [NCH];
   logic [CNT_W-1:0] div_d    [NCH];
   logic [CNT_W-1:0] cnt_q    [NCH];
   logic [CNT_W-1:0] cnt_d    [NCH];
   logic [CNT_W-1:0] shadow_q [NCH];
   logic [CNT_W-1:0] shadow_d [NCH];

   logic [NCH-1:0] clkOut_q;
   logic [NCH-1:0] clkOut_d;
   logic [NCH-1:0] tick_q;
   logic [NCH-1:0] tick_d;
   logic [NCH-1:0] pending_q;
   logic [NCH-1:0] pending_d;
   logic           cfgErr_q;
   logic           cfgErr_d;

   logic [31:0] chIdx;
   logic        chInRange;
   logic        cfgGood;
   logic        cfgXfer;
   logic        pendSel;

   assign chIdx     = 32'(cfg_ch_i);
   assign chInRange = (chIdx < 32'(NCH));
   assign cfgGood   = chInRange && (cfg_div_i >= CNT_W'(2));
   assign cfgXfer   = cfg_valid_i && cfg_ready_o;

   // Pending flag of the addressed channel; an out-of-range channel reads 0 so it is always ready
   always_comb begin
      pendSel = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (chIdx == 32'(i)) begin
            pendSel = pending_q[i];
         end
      end
   end

   assign cfg_ready_o = ~pendSel;

   // Next-state for every channel: count, wrap, fall at half period, and divisor reload
   always_comb begin
      cfgErr_d = cfgXfer && !cfgGood;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]     = cnt_q[i];
         div_d[i]     = div_q[i];
         shadow_d[i]  = shadow_q[i];
         pending_d[i] = pending_q[i];
         clkOut_d[i]  = clkOut_q[i];
         tick_d[i]    = 1'b0;
         if (en_i[i]) begin
            if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
               cnt_d[i]    = '0;
               clkOut_d[i] = 1'b1;
               tick_d[i]   = 1'b1;
               if (pending_q[i]) begin
                  div_d[i]     = shadow_q[i];
                  pending_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
               if (cnt_q[i] == ((div_q[i] - CNT_W'(1)) >> 1)) begin
                  clkOut_d[i] = 1'b0;
               end
            end
         end else begin
            cnt_d[i]    = '0;
            clkOut_d[i] = 1'b0;
            if (pending_q[i]) begin
               div_d[i]     = shadow_q[i];
               pending_d[i] = 1'b0;
            end
         end
         if (cfgXfer && cfgGood && (chIdx == 32'(i))) begin
            if (en_i[i]) begin
               shadow_d[i]  = cfg_div_i;
               pending_d[i] = 1'b1;
            end else begin
               div_d[i] = cfg_div_i;
            end
         end
      end
   end

   // State registers; reset drops all outputs at once and discards queued divisors
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            div_q[i]    <= CNT_W'(DEFAULT_DIV);
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
         clkOut_q  <= '0;
         tick_q    <= '0;
         pending_q <= '0;
         cfgErr_q  <= 1'b0;
      end else begin
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         clkOut_q  <= clkOut_d;
         tick_q    <= tick_d;
         pending_q <= pending_d;
         cfgErr_q  <= cfgErr_d;
      end
   end

   assign clk_out_o = clkOut_q;
   assign tick_o    = tick_q;
   assign pending_o = pending_q;
   assign cfg_err_o = cfgErr_q;

endmodule
